// File: rtl/arm_operand_pkg.sv
// Shared encodings for the execute-stage operand select and shifter.
package arm_operand_pkg;

    localparam logic [1:0] SEL_IMM_SHORT = 2'b00;
    localparam logic [1:0] SEL_RM        = 2'b01;
    localparam logic [1:0] SEL_IMM_LONG  = 2'b10;

    localparam logic [2:0] SH_LSL = 3'b000;
    localparam logic [2:0] SH_LSR = 3'b001;
    localparam logic [2:0] SH_ASR = 3'b010;
    localparam logic [2:0] SH_ROR = 3'b011;
    localparam logic [2:0] SH_RRX = 3'b100;

    function automatic logic sel_reserved(input logic [1:0] sel);
        return (sel != SEL_IMM_SHORT) && (sel != SEL_RM) && (sel != SEL_IMM_LONG);
    endfunction

endpackage

// File: rtl/barrel_shift_core.sv
// Combinational ARM-style shifter (LSL/LSR/ASR/ROR/RRX) with carry-out.
module barrel_shift_core
    import arm_operand_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 8
) (
    input  logic [DATA_W-1:0]  x,
    input  logic [SHAMT_W-1:0] n,
    input  logic [2:0]         sh_type,
    input  logic               carry_in,
    output logic [DATA_W-1:0]  result,
    output logic               carry,
    output logic               type_err
);

    localparam int ROT_W = $clog2(DATA_W);

    // One guard bit next to x catches the last bit shifted out, which covers
    // n = 1..W and makes n > W fall out naturally as zero (or sign for ASR).
    logic [DATA_W:0]        lsl_ext;
    logic [DATA_W:0]        lsr_ext;
    logic signed [DATA_W:0] asr_ext;
    logic [DATA_W-1:0]      ror_val;
    logic [ROT_W-1:0]       rot;
    logic                   n_zero;

    always_comb begin
        n_zero  = (n == '0);
        rot     = n[ROT_W-1:0];
        lsl_ext = {1'b0, x} << n;
        lsr_ext = {x, 1'b0} >> n;
        asr_ext = $signed({x, 1'b0}) >>> n;
        ror_val = (x >> rot) | (x << (DATA_W - int'(rot)));

        result   = x;
        carry    = carry_in;
        type_err = 1'b0;
        case (sh_type)
            SH_LSL: if (!n_zero) begin
                result = lsl_ext[DATA_W-1:0];
                carry  = lsl_ext[DATA_W];
            end
            SH_LSR: if (!n_zero) begin
                result = lsr_ext[DATA_W:1];
                carry  = lsr_ext[0];
            end
            SH_ASR: if (!n_zero) begin
                result = asr_ext[DATA_W:1];
                carry  = asr_ext[0];
            end
            SH_ROR: if (!n_zero) begin
                result = ror_val;
                carry  = ror_val[DATA_W-1];
            end
            SH_RRX: begin
                result = {carry_in, x[DATA_W-1:1]};
                carry  = x[0];
            end
            default: type_err = 1'b1;
        endcase
    end

endmodule

// File: rtl/operand_shift_stage.sv
// Registered operand select / extend / shift stage with a one-deep
// valid/ready output register.
module operand_shift_stage
    import arm_operand_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int IMM_W   = 8,
    parameter int SHAMT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         sel,
    input  logic               imm_sext,
    input  logic [IMM_W-1:0]   imm_short,
    input  logic [DATA_W-1:0]  imm_long,
    input  logic [DATA_W-1:0]  rm,
    input  logic [2:0]         shift_type,
    input  logic [SHAMT_W-1:0] shift_amt,
    input  logic               carry_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  shiftee,
    output logic [DATA_W-1:0]  result,
    output logic               carry_out,
    output logic               enc_err
);

    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] operand;
    logic [DATA_W-1:0] shifted;
    logic              shift_carry;
    logic              type_err;
    logic              accept;

    logic [DATA_W-1:0] shiftee_d, shiftee_q;
    logic [DATA_W-1:0] result_d, result_q;
    logic              carry_out_d, carry_out_q;
    logic              enc_err_d, enc_err_q;
    logic              out_valid_d, out_valid_q;

    always_comb begin
        imm_ext                = {DATA_W{imm_sext & imm_short[IMM_W-1]}};
        imm_ext[IMM_W-1:0]     = imm_short;
        case (sel)
            SEL_IMM_SHORT: operand = imm_ext;
            SEL_RM:        operand = rm;
            SEL_IMM_LONG:  operand = imm_long;
            default:       operand = '0;
        endcase
    end

    barrel_shift_core #(
        .DATA_W  (DATA_W),
        .SHAMT_W (SHAMT_W)
    ) u_shift (
        .x        (operand),
        .n        (shift_amt),
        .sh_type  (shift_type),
        .carry_in (carry_in),
        .result   (shifted),
        .carry    (shift_carry),
        .type_err (type_err)
    );

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // Output register: load on accept, otherwise hold; valid clears on drain.
    always_comb begin
        shiftee_d   = shiftee_q;
        result_d    = result_q;
        carry_out_d = carry_out_q;
        enc_err_d   = enc_err_q;
        out_valid_d = out_valid_q;
        if (accept) begin
            shiftee_d   = operand;
            result_d    = shifted;
            carry_out_d = shift_carry;
            enc_err_d   = sel_reserved(sel) || type_err;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shiftee_q   <= '0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            enc_err_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            shiftee_q   <= shiftee_d;
            result_q    <= result_d;
            carry_out_q <= carry_out_d;
            enc_err_q   <= enc_err_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign shiftee   = shiftee_q;
    assign result    = result_q;
    assign carry_out = carry_out_q;
    assign enc_err   = enc_err_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_operand_shift_stage.sv
// Randomised and directed bench for operand_shift_stage against a bit-serial reference model.
module tb_operand_shift_stage;

    localparam int DATA_W  = 32;
    localparam int IMM_W   = 8;
    localparam int SHAMT_W = 8;
    localparam int PW      = 2 * DATA_W + 2;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [1:0]         sel = '0;
    logic               imm_sext = 1'b0;
    logic [IMM_W-1:0]   imm_short = '0;
    logic [DATA_W-1:0]  imm_long = '0;
    logic [DATA_W-1:0]  rm = '0;
    logic [2:0]         shift_type = '0;
    logic [SHAMT_W-1:0] shift_amt = '0;
    logic               carry_in = 1'b0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic [DATA_W-1:0]  shiftee;
    logic [DATA_W-1:0]  result;
    logic               carry_out;
    logic               enc_err;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    operand_shift_stage #(
        .DATA_W (DATA_W), .IMM_W (IMM_W), .SHAMT_W (SHAMT_W)
    ) dut (
        .clk (clk), .rst_n (rst_n), .in_valid (in_valid), .in_ready (in_ready),
        .sel (sel), .imm_sext (imm_sext), .imm_short (imm_short), .imm_long (imm_long),
        .rm (rm), .shift_type (shift_type), .shift_amt (shift_amt), .carry_in (carry_in),
        .out_valid (out_valid), .out_ready (out_ready), .shiftee (shiftee),
        .result (result), .carry_out (carry_out), .enc_err (enc_err)
    );

    // Reference: shifts are applied one bit at a time; carry is the last bit out.
    function automatic logic [PW-1:0] model(input logic [1:0] s, input logic sx,
            input logic [IMM_W-1:0] is, input logic [DATA_W-1:0] il, input logic [DATA_W-1:0] r,
            input logic [2:0] st, input logic [SHAMT_W-1:0] n, input logic cin);
        logic [DATA_W-1:0] x, res;
        logic c, err;
        int amt;
        err = 1'b0;
        case (s)
            2'd0: begin
                x = DATA_W'(is);
                if (sx && is[IMM_W-1]) for (int i = IMM_W; i < DATA_W; i++) x[i] = 1'b1;
            end
            2'd1: x = r;
            2'd2: x = il;
            default: begin x = '0; err = 1'b1; end
        endcase
        res = x; c = cin; amt = int'(n);
        case (st)
            3'd0: for (int k = 0; k < amt; k++) begin c = res[DATA_W-1]; res = res << 1; end
            3'd1: for (int k = 0; k < amt; k++) begin c = res[0]; res = res >> 1; end
            3'd2: for (int k = 0; k < amt; k++) begin c = res[0]; res = {res[DATA_W-1], res[DATA_W-1:1]}; end
            3'd3: if (amt != 0) begin
                for (int k = 0; k < amt % DATA_W; k++) res = {res[0], res[DATA_W-1:1]};
                c = res[DATA_W-1];
            end
            3'd4: begin res = {cin, x[DATA_W-1:1]}; c = x[0]; end
            default: err = 1'b1;
        endcase
        return {x, res, c, err};
    endfunction

    task automatic drive(input logic [1:0] s, input logic sx, input logic [IMM_W-1:0] is,
            input logic [DATA_W-1:0] il, input logic [DATA_W-1:0] r, input logic [2:0] st,
            input logic [SHAMT_W-1:0] n, input logic cin);
        sel = s; imm_sext = sx; imm_short = is; imm_long = il; rm = r;
        shift_type = st; shift_amt = n; carry_in = cin;
    endtask

    // Present one op at a negedge, let it be captured, return at the following negedge.
    task automatic do_op(input logic [1:0] s, input logic sx, input logic [IMM_W-1:0] is,
            input logic [DATA_W-1:0] il, input logic [DATA_W-1:0] r, input logic [2:0] st,
            input logic [SHAMT_W-1:0] n, input logic cin);
        drive(s, sx, is, il, r, st, n, cin);
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic idle();
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk); @(negedge clk);
        vectors++;
        if ({out_valid, shiftee, result, carry_out, enc_err} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs got v=%b sh=%h res=%h c=%b e=%b want all 0",
                     out_valid, shiftee, result, carry_out, enc_err);
        end
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_extend();
        logic [PW-1:0] want;
        for (int sx = 1; sx >= 0; sx--) begin
            do_op(2'b00, sx[0], 8'h80, '0, '0, 3'b000, '0, 1'b1);
            want = sx ? {32'hFFFF_FF80, 32'hFFFF_FF80, 1'b1, 1'b0}
                      : {32'h0000_0080, 32'h0000_0080, 1'b1, 1'b0};
            vectors++;
            if (out_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL extend_latency sext=%0d out_valid got %b want 1", sx, out_valid);
            end
            vectors++;
            if ({shiftee, result, carry_out, enc_err} !== want) begin
                miscompares++;
                $display("FAIL extend sext=%0d got sh=%h res=%h c=%b e=%b want %h",
                         sx, shiftee, result, carry_out, enc_err, want);
            end
        end
    endtask

    task automatic test_boundary();
        logic [SHAMT_W-1:0] amts [6];
        logic [PW-1:0] want;
        logic cin;
        amts = '{8'd0, 8'd1, 8'd31, 8'd32, 8'd33, 8'd255};
        idle();
        for (int t = 0; t < 3; t++) begin
            for (int a = 0; a < 6; a++) begin
                cin = 1'($urandom);
                do_op(2'b01, 1'b0, '0, '0, 32'h8000_0001, 3'(t), amts[a], cin);
                want = model(2'b01, 1'b0, '0, '0, 32'h8000_0001, 3'(t), amts[a], cin);
                vectors++;
                if ({shiftee, result, carry_out, enc_err} !== want) begin
                    miscompares++;
                    $display("FAIL boundary type=%0d n=%0d cin=%b got res=%h c=%b e=%b want res=%h c=%b e=%b",
                             t, amts[a], cin, result, carry_out, enc_err,
                             want[DATA_W+1 +: DATA_W], want[1], want[0]);
                end
            end
        end
    endtask

    typedef struct packed {
        logic [1:0]         s;
        logic [2:0]         st;
        logic [SHAMT_W-1:0] n;
        logic [DATA_W-1:0]  r;
        logic               cin;
        logic [DATA_W-1:0]  e_sh;
        logic [DATA_W-1:0]  e_res;
        logic               e_c;
        logic               e_err;
    } dvec_t;

    task automatic test_directed();
        dvec_t tbl [9];
        tbl[0] = '{2'b01, 3'd0, 8'd32, 32'h8000_0001, 1'b0, 32'h8000_0001, 32'h0000_0000, 1'b1, 1'b0};
        tbl[1] = '{2'b01, 3'd1, 8'd32, 32'h8000_0001, 1'b0, 32'h8000_0001, 32'h0000_0000, 1'b1, 1'b0};
        tbl[2] = '{2'b01, 3'd2, 8'd40, 32'h8000_0001, 1'b0, 32'h8000_0001, 32'hFFFF_FFFF, 1'b1, 1'b0};
        tbl[3] = '{2'b01, 3'd0, 8'd33, 32'h8000_0001, 1'b1, 32'h8000_0001, 32'h0000_0000, 1'b0, 1'b0};
        tbl[4] = '{2'b01, 3'd3, 8'd1,  32'h0000_0003, 1'b0, 32'h0000_0003, 32'h8000_0001, 1'b1, 1'b0};
        tbl[5] = '{2'b01, 3'd3, 8'd32, 32'h0000_0003, 1'b0, 32'h0000_0003, 32'h0000_0003, 1'b0, 1'b0};
        tbl[6] = '{2'b01, 3'd4, 8'd0,  32'h0000_0003, 1'b0, 32'h0000_0003, 32'h0000_0001, 1'b1, 1'b0};
        tbl[7] = '{2'b11, 3'd0, 8'd0,  32'hDEAD_BEEF, 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1};
        tbl[8] = '{2'b01, 3'd7, 8'd5,  32'h1234_5678, 1'b1, 32'h1234_5678, 32'h1234_5678, 1'b1, 1'b1};
        for (int i = 0; i < 9; i++) begin
            do_op(tbl[i].s, 1'b0, 8'h5A, 32'hCAFE_F00D, tbl[i].r, tbl[i].st, tbl[i].n, tbl[i].cin);
            vectors++;
            if ({shiftee, result, carry_out, enc_err} !== {tbl[i].e_sh, tbl[i].e_res, tbl[i].e_c, tbl[i].e_err}) begin
                miscompares++;
                $display("FAIL directed[%0d] got sh=%h res=%h c=%b e=%b want sh=%h res=%h c=%b e=%b",
                         i, shiftee, result, carry_out, enc_err,
                         tbl[i].e_sh, tbl[i].e_res, tbl[i].e_c, tbl[i].e_err);
            end
        end
    endtask

    task automatic test_random();
        logic [1:0] s; logic sx; logic [IMM_W-1:0] is; logic [DATA_W-1:0] il, r;
        logic [2:0] st; logic [SHAMT_W-1:0] n; logic cin;
        logic [PW-1:0] want;
        for (int i = 0; i < 200; i++) begin
            s = 2'($urandom); sx = 1'($urandom); is = IMM_W'($urandom);
            il = $urandom; r = $urandom; cin = 1'($urandom);
            st = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            case ($urandom_range(0, 3))
                0: n = SHAMT_W'($urandom_range(0, 3));
                1: n = SHAMT_W'($urandom_range(30, 34));
                2: n = SHAMT_W'($urandom_range(60, 66));
                default: n = SHAMT_W'($urandom);
            endcase
            do_op(s, sx, is, il, r, st, n, cin);
            want = model(s, sx, is, il, r, st, n, cin);
            vectors++;
            if ({shiftee, result, carry_out, enc_err} !== want) begin
                miscompares++;
                $display("FAIL random[%0d] sel=%0d type=%0d n=%0d got sh=%h res=%h c=%b e=%b want %h",
                         i, s, st, n, shiftee, result, carry_out, enc_err, want);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [PW-1:0] exp_q [$];
        logic [PW-1:0] ops [4];
        logic [DATA_W-1:0] opr [4];
        logic [2:0] opt [4];
        logic [SHAMT_W-1:0] opn [4];
        logic mv, acc, exp_ready;
        int nxt, drained, last_drain;
        idle();
        for (int i = 0; i < 4; i++) begin
            opr[i] = $urandom; opt[i] = 3'($urandom_range(0, 4)); opn[i] = SHAMT_W'($urandom_range(1, 40));
            ops[i] = model(2'b01, 1'b0, '0, '0, opr[i], opt[i], opn[i], 1'b1);
        end
        mv = 1'b0; nxt = 0; drained = 0; last_drain = -1;
        for (int cyc = 0; cyc < 20 && drained < 4; cyc++) begin
            out_ready = !(cyc >= 2 && cyc <= 4);
            in_valid  = (nxt < 4);
            if (nxt < 4) drive(2'b01, 1'b0, '0, '0, opr[nxt], opt[nxt], opn[nxt], 1'b1);
            #1;
            exp_ready = !mv || out_ready;
            vectors++;
            if (in_ready !== exp_ready) begin
                miscompares++;
                $display("FAIL b2b_in_ready cyc=%0d got %b want %b", cyc, in_ready, exp_ready);
            end
            vectors++;
            if (out_valid !== mv) begin
                miscompares++;
                $display("FAIL b2b_out_valid cyc=%0d got %b want %b", cyc, out_valid, mv);
            end
            if (mv) begin
                vectors++;
                if ({shiftee, result, carry_out, enc_err} !== exp_q[0]) begin
                    miscompares++;
                    $display("FAIL b2b_data cyc=%0d got res=%h c=%b want %h",
                             cyc, result, carry_out, exp_q[0]);
                end
            end
            acc = in_valid && exp_ready;
            if (mv && out_ready) begin
                void'(exp_q.pop_front());
                drained++;
                last_drain = cyc;
            end
            if (acc) begin
                exp_q.push_back(ops[nxt]);
                nxt++;
            end
            mv = acc ? 1'b1 : (out_ready ? 1'b0 : mv);
            @(negedge clk);
        end
        in_valid = 1'b0;
        vectors++;
        if (drained !== 4 || last_drain !== 7) begin
            miscompares++;
            $display("FAIL b2b_throughput drained=%0d last_cycle=%0d want 4 and 7", drained, last_drain);
        end
    endtask

    task automatic test_async_reset();
        logic [PW-1:0] want;
        idle();
        drive(2'b01, 1'b0, '0, '0, 32'hA5A5_0F0F, 3'd1, 8'd4, 1'b1);
        in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL arst_preload out_valid got %b want 1", out_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({out_valid, shiftee, result, carry_out, enc_err, in_ready} !== {1'b0, {PW{1'b0}}, 1'b1}) begin
            miscompares++;
            $display("FAIL arst_immediate got v=%b sh=%h res=%h c=%b e=%b rdy=%b want zeros, rdy=1",
                     out_valid, shiftee, result, carry_out, enc_err, in_ready);
        end
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL arst_no_replay out_valid got %b want 0", out_valid);
        end
        do_op(2'b10, 1'b0, '0, 32'h0000_F00D, '0, 3'd0, 8'd4, 1'b0);
        want = model(2'b10, 1'b0, '0, 32'h0000_F00D, '0, 3'd0, 8'd4, 1'b0);
        vectors++;
        if ({out_valid, shiftee, result, carry_out, enc_err} !== {1'b1, want}) begin
            miscompares++;
            $display("FAIL arst_next_op got v=%b res=%h c=%b want v=1 %h",
                     out_valid, result, carry_out, want);
        end
    endtask

    initial begin
        test_reset();
        test_extend();
        test_boundary();
        test_directed();
        test_random();
        test_back_to_back();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/operand_shift_stage.md
# operand_shift_stage

Registered operand-select and shift stage for the execute pipeline. It picks the shifter operand from a short immediate (sign- or zero-extended), a long immediate or the register operand. It applies an ARM-style shift (LSL/LSR/ASR/ROR/RRX) with carry-out and delivers the result one cycle later behind a valid/ready handshake. Successor to the combinational shiftee select: width-parametrised, extension-mode aware, pipelined, and with defined behaviour for reserved encodings.

## Interface
- DATA_W, 32, operand/result width; power of two, ≥8
- IMM_W, 8, short-immediate width; 1..DATA_W
- SHAMT_W, 8, shift-amount width; ≥ log2(DATA_W)+1
- clk  in  1  clock
- rst_n  in  1  reset; one clock, asynchronous assert, active-low
- in_valid  in  1  input operation valid
- in_ready  out  1  stage can accept
- sel  in  2  00 short imm, 01 rm, 10 long imm, 11 reserved
- imm_sext  in  1  1 = sign-extend short imm, 0 = zero-extend
- imm_short  in  IMM_W  short immediate
- imm_long  in  DATA_W  long immediate
- rm  in  DATA_W  register operand
- shift_type  in  3  000 LSL, 001 LSR, 010 ASR, 011 ROR, 100 RRX, 101–111 reserved
- shift_amt  in  SHAMT_W  unsigned shift amount
- carry_in  in  1  current C flag
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts
- shiftee  out  DATA_W  selected, extended operand before shifting
- result  out  DATA_W  shifted operand
- carry_out  out  1  shifter carry
- enc_err  out  1  reserved sel or shift_type was used

## Operation
- Selection: reserved sel yields operand 0 and enc_err=1. Reserved shift_type yields result=shiftee, carry_out=carry_in, enc_err=1.
- Extension: the short immediate is placed in the low IMM_W bits. The upper bits are imm_short[IMM_W-1] if imm_sext, else 0.
- Shift rules: x = shiftee, n = shift_amt, W = DATA_W.
  - All types with n=0 (except RRX): result=x, c=carry_in.
  - LSL 1..W-1: x<<n, c=x[W-n]. LSL n=W: 0, c=x[0]. LSL n>W: 0, c=0.
  - LSR 1..W-1: x>>n, c=x[n-1]. LSR n=W: 0, c=x[W-1]. LSR n>W: 0, c=0.
  - ASR 1..W-1: arithmetic shift, c=x[n-1]. ASR n≥W: all bits = x[W-1], c=x[W-1].
  - ROR, n≠0: rotate right by n mod W. If n mod W = 0, result=x. In both cases c=result[W-1].
  - RRX ignores n: result={carry_in, x[W-1:1]}, c=x[0].
- Only the combinational evaluation of the shift rules is unregistered. Output fields are captured together in one output register.

## Timing
- Latency: 1 cycle, from an accepted input to out_valid.
- in_ready = !out_valid || out_ready (combinational).
- An input is accepted when in_valid && in_ready. On the next edge, the register loads and out_valid=1.
- out_valid drops on the edge where out_valid && out_ready && !(in_valid && in_ready). Simultaneous accept and drain reloads the register and keeps out_valid=1. Full throughput is 1 op/cycle.
- While out_valid && !out_ready, all outputs hold stable and no input is accepted.
- Reset values: out_valid=0, shiftee=0, result=0, carry_out=0, enc_err=0. in_ready reads 1 during reset.
- Reset mid-operation: the in-flight result is discarded and nothing is replayed. The first accept after rst_n rises is a normal op.
- Payload inputs are don't-care when in_valid=0. Outputs other than out_valid are don't-care when out_valid=0, but must still hold their reset values until the first load.

## Structure
- Shared package arm_operand_pkg holds:
  - the sel encodings (SEL_IMM_SHORT, SEL_RM, SEL_IMM_LONG);
  - the shift_type encodings (SH_LSL, SH_LSR, SH_ASR, SH_ROR, SH_RRX).
- The existing shiftee select migrates to the same sel constants.
- Sub-module barrel_shift_core: purely combinational, takes x, n, type and carry_in, and returns result and carry. It is instantiated once and reused by the ALU immediate path.
- The top level contains the select/extend logic, the handshake and the output register.

## Test plan
- Reset, then one op: sel=00, imm_short=8'h80, imm_sext=1, LSL #0, carry_in=1 → next cycle shiftee=result=32'hFFFF_FF80, carry_out=1. Same op with imm_sext=0 → 32'h0000_0080.
- LSL/LSR/ASR boundary sweep on rm=32'h8000_0001 with n ∈ {0,1,31,32,33,255}:
  - LSL #32 → 0, c=1; LSR #32 → 0, c=1; ASR #40 → 32'hFFFF_FFFF, c=1; LSL #33 → 0, c=0.
- ROR and RRX on rm=32'h0000_0003, carry_in=0:
  - ROR #1 → 32'h8000_0001, c=1; ROR #32 → 32'h0000_0003, c=0; RRX → 32'h0000_0001, c=1.
- Reserved encodings: sel=11 → shiftee=0, enc_err=1. shift_type=111 with rm=32'h1234_5678 → result=32'h1234_5678, carry_out=carry_in, enc_err=1.
- Backpressure: stream 4 ops with out_ready low for 3 cycles mid-stream:
  - outputs stay stable and in_ready=0 while stalled;
  - all 4 results emerge in order with no loss or duplication;
  - back-to-back throughput is 1/cycle when out_ready=1.
- Asynchronous reset asserted between clock edges with out_valid=1 → out_valid=0 immediately and all outputs at reset values. The next accepted op completes normally.
